// File: rtl/median_pkg.sv
// Shared constants, FSM encoding and tap geometry for the median window fetcher.
// Taps are numbered row-major across the 3x3 neighbourhood, top-left first.
package median_pkg;

    localparam int CHANNELS    = 3;
    localparam int DATA_WIDTH  = 24;
    localparam int KERNEL_TAPS = 9;
    localparam int TAP_WIDTH   = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic signed [1:0] dr;
        logic signed [1:0] dc;
    } tap_offset_t;

    // Row/column offset of tap k relative to the centre pixel.
    function automatic tap_offset_t tap_offset(input logic [TAP_WIDTH-1:0] k);
        tap_offset_t o;
        case (k)
            4'd0, 4'd1, 4'd2: o.dr = -2'sd1;
            4'd3, 4'd4, 4'd5: o.dr = 2'sd0;
            default:          o.dr = 2'sd1;
        endcase
        case (k)
            4'd0, 4'd3, 4'd6: o.dc = -2'sd1;
            4'd1, 4'd4, 4'd7: o.dc = 2'sd0;
            default:          o.dc = 2'sd1;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/median_window_fetch_if.sv
// Memory read port and window handshake of the median window fetcher.
// master = fetcher side, slave = memory/consumer side.
interface median_window_fetch_if #(
    parameter int BUS_WIDTH   = 32,
    parameter int DATA_WIDTH  = median_pkg::DATA_WIDTH,
    parameter int KERNEL_TAPS = median_pkg::KERNEL_TAPS
);
    logic                              Fetch_Read_Enable;
    logic [BUS_WIDTH-1:0]              Fetch_Read_Address;
    logic                              Fetch_Mem_Grant;
    logic [DATA_WIDTH-1:0]             Mem_Output_Data;
    logic                              Win_Valid;
    logic                              Win_Ready;
    logic [KERNEL_TAPS*DATA_WIDTH-1:0] Win_Data;

    modport master (
        output Fetch_Read_Enable, Fetch_Read_Address, Win_Valid, Win_Data,
        input  Fetch_Mem_Grant, Mem_Output_Data, Win_Ready
    );

    modport slave (
        input  Fetch_Read_Enable, Fetch_Read_Address, Win_Valid, Win_Data,
        output Fetch_Mem_Grant, Mem_Output_Data, Win_Ready
    );
endinterface

// File: rtl/median_window_addr.sv
// Combinational byte address of one window tap, with edge-pixel replication
// at all image borders.
module median_window_addr #(
    parameter int CHANNELS    = median_pkg::CHANNELS,
    parameter int BUS_WIDTH   = 32,
    parameter int COORD_WIDTH = 12
) (
    input  logic [median_pkg::TAP_WIDTH-1:0] tap,
    input  logic [COORD_WIDTH-1:0]           x,
    input  logic [COORD_WIDTH-1:0]           y,
    input  logic [COORD_WIDTH-1:0]           width,
    input  logic [COORD_WIDTH-1:0]           height,
    input  logic [BUS_WIDTH-1:0]             base,
    output logic [BUS_WIDTH-1:0]             addr
);
    import median_pkg::*;

    tap_offset_t              off;
    logic signed [COORD_WIDTH:0] xs, ys, x_max, y_max;
    logic [COORD_WIDTH-1:0]   xx, yy;
    logic [BUS_WIDTH-1:0]     pix_idx;

    always_comb begin
        off   = tap_offset(tap);
        // One extra bit keeps X-1 at X=0 negative instead of wrapping.
        xs    = $signed({1'b0, x}) + $signed({{(COORD_WIDTH-1){off.dc[1]}}, off.dc});
        ys    = $signed({1'b0, y}) + $signed({{(COORD_WIDTH-1){off.dr[1]}}, off.dr});
        x_max = $signed({1'b0, width  - COORD_WIDTH'(1)});
        y_max = $signed({1'b0, height - COORD_WIDTH'(1)});

        if (xs[COORD_WIDTH])  xx = '0;
        else if (xs > x_max)  xx = x_max[COORD_WIDTH-1:0];
        else                  xx = xs[COORD_WIDTH-1:0];

        if (ys[COORD_WIDTH])  yy = '0;
        else if (ys > y_max)  yy = y_max[COORD_WIDTH-1:0];
        else                  yy = ys[COORD_WIDTH-1:0];

        pix_idx = BUS_WIDTH'(yy) * BUS_WIDTH'(width) + BUS_WIDTH'(xx);
        addr    = base + BUS_WIDTH'(CHANNELS) * pix_idx;
    end

endmodule

// File: rtl/median_window_fetch.sv
// Fetches the 3x3 RGB neighbourhood of one pixel from byte-addressed memory
// and presents it as a single 9-tap window to the median datapath.
module median_window_fetch #(
    parameter int CHANNELS    = median_pkg::CHANNELS,
    parameter int DATA_WIDTH  = median_pkg::DATA_WIDTH,
    parameter int BUS_WIDTH   = 32,
    parameter int COORD_WIDTH = 12
) (
    input  logic                   Fetch_Clk,
    input  logic                   Fetch_Reset,
    input  logic                   Fetch_Start,
    input  logic [BUS_WIDTH-1:0]   Fetch_Base_Address,
    input  logic [COORD_WIDTH-1:0] Fetch_Width,
    input  logic [COORD_WIDTH-1:0] Fetch_Height,
    input  logic [COORD_WIDTH-1:0] Fetch_X,
    input  logic [COORD_WIDTH-1:0] Fetch_Y,
    output logic                   Fetch_Busy,
    median_window_fetch_if.master  bus
);
    import median_pkg::*;

    logic [1:0]             state;
    logic [TAP_WIDTH-1:0]   tap;
    logic [BUS_WIDTH-1:0]   base_q;
    logic [COORD_WIDTH-1:0] width_q, height_q, x_q, y_q;

    logic [TAP_WIDTH-1:0]   addr_tap;
    logic [BUS_WIDTH-1:0]   addr_base;
    logic [COORD_WIDTH-1:0] addr_x, addr_y, addr_w, addr_h;
    logic [BUS_WIDTH-1:0]   addr_next;

    logic                   cap_pend;
    logic [TAP_WIDTH-1:0]   cap_tap;
    logic [DATA_WIDTH-1:0]  win [KERNEL_TAPS];
    logic                   issue;

    assign issue      = (state == ST_ISSUE) && bus.Fetch_Read_Enable && bus.Fetch_Mem_Grant;
    assign Fetch_Busy = (state != ST_IDLE);

    // In IDLE the tap-0 address comes straight from the request ports so it
    // can be registered on the same edge that accepts Start.
    always_comb begin
        if (state == ST_IDLE) begin
            addr_tap  = '0;
            addr_base = Fetch_Base_Address;
            addr_x    = Fetch_X;
            addr_y    = Fetch_Y;
            addr_w    = Fetch_Width;
            addr_h    = Fetch_Height;
        end else begin
            addr_tap  = tap + TAP_WIDTH'(1);
            addr_base = base_q;
            addr_x    = x_q;
            addr_y    = y_q;
            addr_w    = width_q;
            addr_h    = height_q;
        end
    end

    median_window_addr #(
        .CHANNELS    (CHANNELS),
        .BUS_WIDTH   (BUS_WIDTH),
        .COORD_WIDTH (COORD_WIDTH)
    ) u_addr (
        .tap    (addr_tap),
        .x      (addr_x),
        .y      (addr_y),
        .width  (addr_w),
        .height (addr_h),
        .base   (addr_base),
        .addr   (addr_next)
    );

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Fetch_Clk) begin
        if (Fetch_Reset) begin
            state                  <= ST_IDLE;
            tap                    <= '0;
            base_q                 <= '0;
            width_q                <= '0;
            height_q               <= '0;
            x_q                    <= '0;
            y_q                    <= '0;
            cap_pend               <= 1'b0;
            cap_tap                <= '0;
            bus.Fetch_Read_Enable  <= 1'b0;
            bus.Fetch_Read_Address <= '0;
            bus.Win_Valid          <= 1'b0;
            // NOTE: the window store is a small register bank, not a RAM, and
            // must read back as zero after reset, so clearing it is intended.
            for (int k = 0; k < KERNEL_TAPS; k++) win[k] <= '0;
        end else begin
            cap_pend <= issue;
            cap_tap  <= tap;
            if (cap_pend) win[cap_tap] <= bus.Mem_Output_Data;

            case (state)
                ST_IDLE: begin
                    if (Fetch_Start) begin
                        base_q                 <= Fetch_Base_Address;
                        width_q                <= Fetch_Width;
                        height_q               <= Fetch_Height;
                        x_q                    <= Fetch_X;
                        y_q                    <= Fetch_Y;
                        tap                    <= '0;
                        bus.Fetch_Read_Enable  <= 1'b1;
                        bus.Fetch_Read_Address <= addr_next;
                        state                  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue) begin
                        if (tap == TAP_WIDTH'(KERNEL_TAPS - 1)) begin
                            bus.Fetch_Read_Enable <= 1'b0;
                            state                 <= ST_DRAIN;
                        end else begin
                            tap                    <= tap + TAP_WIDTH'(1);
                            bus.Fetch_Read_Address <= addr_next;
                        end
                    end
                end
                ST_DRAIN: begin
                    bus.Win_Valid <= 1'b1;
                    state         <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.Win_Ready) begin
                        bus.Win_Valid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.Win_Data = '0;
        for (int k = 0; k < KERNEL_TAPS; k++)
            bus.Win_Data[(KERNEL_TAPS-1-k)*DATA_WIDTH +: DATA_WIDTH] = win[k];
    end

endmodule

// File: tb/tb_median_window_fetch.sv
// Scoreboard bench for median_window_fetch: directed windows with hand-computed
// pixel indices, grant stalls, backpressure, mid-fetch reset and degenerate image.
module tb_median_window_fetch;
    import median_pkg::*;

    localparam int BW    = 32;
    localparam int CW    = 12;
    localparam int DW    = 24;
    localparam int WIN_W = KERNEL_TAPS * DW;
    localparam logic [BW-1:0] MEM_ORIGIN = 32'h100;

    typedef int idx_t [KERNEL_TAPS];

    logic          Fetch_Clk = 1'b0;
    logic          Fetch_Reset = 1'b1;
    logic          Fetch_Start = 1'b0;
    logic [BW-1:0] Fetch_Base_Address = '0;
    logic [CW-1:0] Fetch_Width = '0, Fetch_Height = '0, Fetch_X = '0, Fetch_Y = '0;
    logic          Fetch_Busy;

    median_window_fetch_if #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) bus ();

    median_window_fetch #(
        .CHANNELS(3), .DATA_WIDTH(DW), .BUS_WIDTH(BW), .COORD_WIDTH(CW)
    ) dut (
        .Fetch_Clk          (Fetch_Clk),
        .Fetch_Reset        (Fetch_Reset),
        .Fetch_Start        (Fetch_Start),
        .Fetch_Base_Address (Fetch_Base_Address),
        .Fetch_Width        (Fetch_Width),
        .Fetch_Height       (Fetch_Height),
        .Fetch_X            (Fetch_X),
        .Fetch_Y            (Fetch_Y),
        .Fetch_Busy         (Fetch_Busy),
        .bus                (bus)
    );

    always #5 Fetch_Clk = ~Fetch_Clk;

    int tests = 0;
    int fails = 0;
    logic [BW-1:0]    addr_q [$];
    logic [WIN_W-1:0] win_q  [$];

    task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory image: the pixel with index p (from MEM_ORIGIN) holds byte p in all three channels.
    function automatic logic [7:0] mem_byte(input logic [BW-1:0] a);
        return 8'((a - MEM_ORIGIN) / 3);
    endfunction

    function automatic logic [DW-1:0] mem_read(input logic [BW-1:0] a);
        return {mem_byte(a), mem_byte(a + 1), mem_byte(a + 2)};
    endfunction

    always @(posedge Fetch_Clk)
        if (bus.Fetch_Read_Enable && bus.Fetch_Mem_Grant)
            bus.Mem_Output_Data <= mem_read(bus.Fetch_Read_Address);

    // Address monitor: every issued read is compared against the expected queue.
    initial forever begin
        @(negedge Fetch_Clk);
        if (bus.Fetch_Read_Enable === 1'b1 && bus.Fetch_Mem_Grant === 1'b1) begin
            if (addr_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL read_unexpected: got %0h expected no read", bus.Fetch_Read_Address);
            end else begin
                check("read_address", bus.Fetch_Read_Address, addr_q.pop_front());
            end
        end
    end

    // Window monitor: compares once per Win_Valid assertion.
    initial begin
        bit seen = 1'b0;
        forever begin
            @(negedge Fetch_Clk);
            if (bus.Win_Valid === 1'b1) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (win_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL window_unexpected: got %0h expected no window", bus.Win_Data);
                    end else begin
                        check("window", bus.Win_Data, win_q.pop_front());
                    end
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    task automatic run_window(input logic [BW-1:0] base, input logic [CW-1:0] w, input logic [CW-1:0] h,
                              input logic [CW-1:0] x, input logic [CW-1:0] y, input idx_t idx,
                              input bit stall, input bit bp, input int exp_lat);
        logic [WIN_W-1:0] exp_win, snap;
        logic [BW-1:0]    hold;
        logic [7:0]       b;
        int               count;
        exp_win = '0;
        for (int k = 0; k < KERNEL_TAPS; k++) begin
            b = idx[k][7:0];
            addr_q.push_back(MEM_ORIGIN + BW'(3 * idx[k]));
            exp_win[(KERNEL_TAPS-1-k)*DW +: DW] = {b, b, b};
        end
        win_q.push_back(exp_win);
        hold = MEM_ORIGIN + BW'(3 * idx[5]);

        Fetch_Base_Address = base;
        Fetch_Width = w; Fetch_Height = h; Fetch_X = x; Fetch_Y = y;
        Fetch_Start = 1'b1;
        @(posedge Fetch_Clk); #1;
        Fetch_Start = 1'b0;
        count = 0;
        while (count < 40) begin
            @(posedge Fetch_Clk); #1;
            count++;
            if (stall && count == 5) bus.Fetch_Mem_Grant = 1'b0;
            if (stall && count == 8) bus.Fetch_Mem_Grant = 1'b1;
            if (!bus.Fetch_Mem_Grant) check("stall_addr_hold", bus.Fetch_Read_Address, hold);
            if (bus.Win_Valid) break;
        end
        check("latency", count, exp_lat);

        if (bp) begin
            snap = bus.Win_Data;
            for (int c = 0; c < 5; c++) begin
                Fetch_Start = (c == 1);
                @(posedge Fetch_Clk); #1;
                check("bp_valid_held", bus.Win_Valid, 1);
                check("bp_data_held", bus.Win_Data, snap);
            end
            Fetch_Start = 1'b0;
            bus.Win_Ready = 1'b1;
        end
        @(posedge Fetch_Clk); #1;
        check("idle_after_accept", {bus.Win_Valid, Fetch_Busy}, 0);
        if (bp) begin
            @(posedge Fetch_Clk); #1;
            check("start_ignored_in_done", {bus.Fetch_Read_Enable, Fetch_Busy}, 0);
        end
    endtask

    task automatic reset_mid_fetch();
        idx_t idx;
        idx = '{18, 19, 20, 26, 27, 28, 34, 35, 36};
        for (int k = 0; k < 5; k++) addr_q.push_back(MEM_ORIGIN + BW'(3 * idx[k]));
        Fetch_Base_Address = MEM_ORIGIN;
        Fetch_Width = 8; Fetch_Height = 8; Fetch_X = 3; Fetch_Y = 3;
        Fetch_Start = 1'b1;
        @(posedge Fetch_Clk); #1;
        Fetch_Start = 1'b0;
        repeat (4) @(posedge Fetch_Clk);
        #1;
        Fetch_Reset = 1'b1;
        @(posedge Fetch_Clk); #1;
        Fetch_Reset = 1'b0;
        check("rst_mid_read_enable", bus.Fetch_Read_Enable, 0);
        check("rst_mid_address", bus.Fetch_Read_Address, 0);
        check("rst_mid_busy", Fetch_Busy, 0);
        check("rst_mid_valid", bus.Win_Valid, 0);
        check("rst_mid_data", bus.Win_Data, 0);
        @(posedge Fetch_Clk); #1;
        check("rst_mid_late_data_ignored", bus.Win_Data, 0);
        check("rst_mid_stays_idle", {bus.Fetch_Read_Enable, Fetch_Busy}, 0);
    endtask

    initial begin
        bus.Fetch_Mem_Grant = 1'b1;
        bus.Win_Ready       = 1'b1;
        bus.Mem_Output_Data = '0;
        repeat (3) @(posedge Fetch_Clk);
        #1;
        Fetch_Reset = 1'b0;
        check("reset_read_enable", bus.Fetch_Read_Enable, 0);
        check("reset_address", bus.Fetch_Read_Address, 0);
        check("reset_busy", Fetch_Busy, 0);
        check("reset_valid", bus.Win_Valid, 0);
        check("reset_data", bus.Win_Data, 0);

        run_window(MEM_ORIGIN, 8, 8, 3, 3, '{18, 19, 20, 26, 27, 28, 34, 35, 36}, 1'b0, 1'b0, 10);
        run_window(MEM_ORIGIN, 8, 8, 0, 0, '{0, 0, 1, 0, 0, 1, 8, 8, 9}, 1'b0, 1'b0, 10);
        run_window(MEM_ORIGIN, 8, 8, 7, 7, '{54, 55, 55, 62, 63, 63, 62, 63, 63}, 1'b0, 1'b0, 10);
        run_window(MEM_ORIGIN, 5, 4, 4, 0, '{3, 4, 4, 3, 4, 4, 8, 9, 9}, 1'b0, 1'b0, 10);
        run_window(MEM_ORIGIN, 8, 8, 3, 3, '{18, 19, 20, 26, 27, 28, 34, 35, 36}, 1'b1, 1'b0, 13);

        bus.Win_Ready = 1'b0;
        run_window(MEM_ORIGIN, 8, 8, 0, 0, '{0, 0, 1, 0, 0, 1, 8, 8, 9}, 1'b0, 1'b1, 10);

        reset_mid_fetch();
        run_window(MEM_ORIGIN, 8, 8, 3, 3, '{18, 19, 20, 26, 27, 28, 34, 35, 36}, 1'b0, 1'b0, 10);

        // Single-pixel image based at memory pixel 5: every tap replicates it.
        run_window(MEM_ORIGIN + 32'd15, 1, 1, 0, 0, '{5, 5, 5, 5, 5, 5, 5, 5, 5}, 1'b0, 1'b0, 10);

        repeat (3) @(posedge Fetch_Clk);
        #1;
        check("addr_queue_drained", addr_q.size(), 0);
        check("window_queue_drained", win_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
